// File: rtl/audio_sample_dpram.sv
// Purpose : 256 x 128-bit simple dual-port, dual-clock sample buffer (write on Clk50, read on rdclock).
// Latency : write lands on the Clk50 edge with wren=1; q is registered, 1 rdclock cycle after rdaddress.
// Backpr. : none; one write per Clk50 cycle and one read per rdclock cycle, no stall.
//
// Ports:
//   Clk50     - write clock (rising edge)
//   reset     - synchronous active-high reset in the Clk50 domain; blocks writes, clears q via synchronizer
//   rdclock   - read clock, asynchronous to Clk50 (rising edge)
//   wraddress - write address (Clk50)
//   wren      - write enable (Clk50)
//   data      - write data (Clk50)
//   rdaddress - read address (rdclock)
//   q         - registered read data (rdclock)
module audio_sample_dpram #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 8
) (
   input  logic              Clk50,
   input  logic              reset,
   input  logic              rdclock,
   input  logic [ADDR_W-1:0] wraddress,
   input  logic              wren,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] rdaddress,
   output logic [DATA_W-1:0] q
);

   localparam int DEPTH = 1 << ADDR_W;

   // Storage is deliberately never cleared: reset only blocks writes, so
   // buffered samples survive a reset pulse.
   logic [DATA_W-1:0] mem [DEPTH];

   logic wr_en;
   assign wr_en = wren & ~reset;

   always_ff @(posedge Clk50) begin
      if (wr_en) begin
         mem[wraddress] <= data;
      end
   end

   // Read side: reset crosses into rdclock through two flops before it is
   // allowed to force q, so q never sees a metastable clear.
   logic              rst_meta_d, rst_meta_q;
   logic              rst_rd_d,   rst_rd_q;
   logic [DATA_W-1:0] q_d,        q_q;

   always_comb begin
      rst_meta_d = reset;
      rst_rd_d   = rst_meta_q;
      q_d        = mem[rdaddress];
      if (rst_rd_q) begin
         q_d = '0;
      end
   end

   always_ff @(posedge rdclock) begin
      rst_meta_q <= rst_meta_d;
      rst_rd_q   <= rst_rd_d;
      q_q        <= q_d;
   end

   assign q = q_q;

endmodule

// File: tb/tb_audio_sample_dpram.sv
`timescale 1ns/1ps
module tb_audio_sample_dpram;

   logic         Clk50;
   logic         reset;
   logic         rdclock;
   logic [7:0]   wraddress;
   logic         wren;
   logic [127:0] data;
   logic [7:0]   rdaddress;
   logic [127:0] q;

   int checks   = 0;
   int failures = 0;

   real rd_half = 170.0;   // rdclock = Clk50 / 17

   logic [127:0] ref_mem [256];
   logic [127:0] exp_q [$];
   string        tag_q [$];
   int           wr_cnt;

   localparam logic [127:0] ONES = {128{1'b1}};

   audio_sample_dpram #(.DATA_W(128), .ADDR_W(8)) dut (
      .Clk50     (Clk50),
      .reset     (reset),
      .rdclock   (rdclock),
      .wraddress (wraddress),
      .wren      (wren),
      .data      (data),
      .rdaddress (rdaddress),
      .q         (q)
   );

   initial Clk50 = 1'b0;
   always #10 Clk50 = ~Clk50;

   initial rdclock = 1'b0;
   always #(rd_half) rdclock = ~rdclock;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [127:0] d);
      @(posedge Clk50); #1;
      wren      = 1'b1;
      wraddress = a;
      data      = d;
      if (!reset) ref_mem[a] = d;
   endtask

   task automatic wr_idle();
      @(posedge Clk50); #1;
      wren = 1'b0;
      repeat (2) @(posedge rdclock);
   endtask

   // One rdclock step: compare the word requested on the previous step, then
   // present the next address and push its expected word.
   task automatic rd_step(input logic [7:0] a, input bit push);
      logic [127:0] e;
      string        t;
      @(posedge rdclock); #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk(t, q, e);
      end
      rdaddress = a;
      if (push) begin
         exp_q.push_back(ref_mem[a]);
         tag_q.push_back($sformatf("rd_%02h", a));
      end
   endtask

   task automatic flush();
      rd_step(rdaddress, 1'b0);
   endtask

   initial begin
      logic [7:0]   a8;
      logic [127:0] w;
      reset = 1'b1; wren = 1'b0; wraddress = '0; data = '0; rdaddress = '0; wr_cnt = 0;

      // reset state
      repeat (3) @(posedge rdclock); #1;
      chk("reset_q", q, '0);
      @(posedge Clk50); #1 reset = 1'b0;
      repeat (3) @(posedge rdclock);

      // basic write / read
      wr(8'h05, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
      wr(8'h06, ONES);
      wr_idle();
      rd_step(8'h05, 1'b1);
      rd_step(8'h06, 1'b1);
      flush();

      // full sweep, back-to-back writes
      for (int i = 0; i < 256; i++) begin
         a8 = i[7:0];
         wr(a8, {16{a8}});
      end
      wr_idle();
      for (int i = 0; i < 256; i++) rd_step(i[7:0], 1'b1);
      rd_step(8'h00, 1'b1);   // wrap back to 0x00
      flush();

      // write enable gating
      wr(8'h10, 128'h1234);
      wr_idle();
      @(posedge Clk50); #1;
      wren = 1'b0; wraddress = 8'h10; data = {8{16'hDEAD}};
      repeat (4) @(posedge Clk50);
      repeat (2) @(posedge rdclock);
      rd_step(8'h10, 1'b1);
      flush();

      // reset: contents retained, write during reset ignored, q cleared
      wr(8'h20, {32{4'hA, 4'h5}});
      wr_idle();
      rdaddress = 8'h20;
      @(posedge Clk50); #1;
      reset = 1'b1; wren = 1'b1; wraddress = 8'h21; data = {8{16'hBEEF}};
      repeat (3) @(posedge rdclock); #1;
      chk("reset_mid_q", q, '0);
      @(posedge rdclock); #1;
      chk("reset_hold_q", q, '0);
      @(posedge Clk50); #1;
      reset = 1'b0; wren = 1'b0;
      repeat (3) @(posedge rdclock);
      rd_step(8'h20, 1'b1);
      rd_step(8'h21, 1'b1);
      flush();

      // asynchronous clocks, writes streamed ahead of reads
      rd_half = 177.154;
      #($urandom_range(0, 350));
      fork
         begin
            for (int i = 0; i < 64; i++) begin
               a8 = 8'h80 + i[7:0];
               w  = {$urandom, $urandom, $urandom, $urandom};
               wr(a8, w);
               @(posedge Clk50); #1 wren = 1'b0;
               wr_cnt++;
               repeat (14) @(posedge Clk50);
            end
         end
         begin
            wait (wr_cnt >= 6);
            for (int j = 0; j < 64; j++) begin
               wait (wr_cnt >= ((j + 5 < 64) ? j + 5 : 64));
               rd_step(8'h80 + j[7:0], 1'b1);
            end
            flush();
         end
      join
      repeat (2) @(posedge rdclock);

      // collision on 0x40: 0 -> all ones near a read edge
      wr(8'h40, '0);
      wr_idle();
      @(posedge rdclock); #1 rdaddress = 8'h40;
      @(posedge rdclock); #1;
      chk("coll_pre", q, '0);
      #(2.0 * rd_half - 37.0);
      @(posedge Clk50); #1;
      wren = 1'b1; wraddress = 8'h40; data = ONES;
      ref_mem[8'h40] = ONES;
      @(posedge rdclock); #1;
      checks++;
      assert (q === '0 || q === ONES) else begin
         failures++;
         $error("FAIL coll_either observed=%h expected=all0_or_all1", q);
      end
      @(posedge Clk50); #1 wren = 1'b0;
      repeat (2) @(posedge rdclock); #1;
      chk("coll_after", q, ONES);

      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
